sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 38 +++
 rtl/sram_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Signal bundle between the CPU/video requesters, the SRAM pins and the arbiter.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface sram_arbiter_if #(
  parameter int ADDR_W = 18
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [7:0]        vid_rdata;

  logic              RAMCS_b;
  logic              RAMOE_b;
  logic              RAMWE_b;
  logic [ADDR_W-1:0] ADR;
  logic [7:0]        dat_out;
  logic              dat_oe;
  logic [7:0]        dat_in;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, dat_in,
    output cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    output RAMCS_b, RAMOE_b, RAMWE_b, ADR, dat_out, dat_oe, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, dat_in,
    input  cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    input  RAMCS_b, RAMOE_b, RAMWE_b, ADR, dat_out, dat_oe, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port (CPU read/write, video read-only) round-robin arbiter for an
// asynchronous byte-wide SRAM with registered strobes and parameterised timing.
module sram_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, WR_HOLD} state_e;
  typedef enum logic {OWN_CPU = 1'b0, OWN_VID = 1'b1} owner_e;

  localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [7:0]        dout_q, dout_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        vid_rdata_q, vid_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vid_ack_q, vid_ack_d;
  logic              cs_b_q, cs_b_d;
  logic              oe_b_q, oe_b_d;
  logic              we_b_q, we_b_d;
  logic              dat_oe_q, dat_oe_d;

  logic cpu_pend, vid_pend, grant_vid;

  // A request seen in its own ack cycle is stale and must not retrigger.
  assign cpu_pend  = bus.cpu_req & ~cpu_ack_q;
  assign vid_pend  = bus.vid_req & ~vid_ack_q;
  assign grant_vid = vid_pend & (~cpu_pend | (last_grant_q == OWN_CPU));

  always_comb begin
    // NOTE: every _d gets its default first, so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    adr_d        = adr_q;
    dout_d       = dout_q;
    cpu_rdata_d  = cpu_rdata_q;
    vid_rdata_d  = vid_rdata_q;
    cpu_ack_d    = 1'b0;
    vid_ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_pend || vid_pend) begin
          owner_d      = grant_vid ? OWN_VID : OWN_CPU;
          last_grant_d = owner_d;
          cnt_d        = '0;
          if (grant_vid) begin
            adr_d   = bus.vid_addr;
            state_d = RD;
          end else begin
            adr_d = bus.cpu_addr;
            if (bus.cpu_we) begin
              dout_d  = bus.cpu_wdata;
              state_d = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          state_d = IDLE;
          if (owner_q == OWN_VID) begin
            vid_rdata_d = bus.dat_in;
            vid_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = bus.dat_in;
            cpu_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR: begin
        if (cnt_q == WR_LAST) state_d = WR_HOLD;
        else                  cnt_d   = cnt_q + 4'd1;
      end
      WR_HOLD: begin
        // Only the CPU can own a write.
        state_d   = IDLE;
        cpu_ack_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Strobes follow the next state so the pins are registered, not decoded.
    cs_b_d   = (state_d == IDLE);
    oe_b_d   = (state_d != RD);
    we_b_d   = (state_d != WR);
    dat_oe_d = (state_d == WR) || (state_d == WR_HOLD);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_CPU;
      adr_q        <= '0;
      dout_q       <= '0;
      cpu_rdata_q  <= '0;
      vid_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      vid_ack_q    <= 1'b0;
      cs_b_q       <= 1'b1;
      oe_b_q       <= 1'b1;
      we_b_q       <= 1'b1;
      dat_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      adr_q        <= adr_d;
      dout_q       <= dout_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vid_rdata_q  <= vid_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      vid_ack_q    <= vid_ack_d;
      cs_b_q       <= cs_b_d;
      oe_b_q       <= oe_b_d;
      we_b_q       <= we_b_d;
      dat_oe_q     <= dat_oe_d;
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vid_ack   = vid_ack_q;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.RAMCS_b   = cs_b_q;
  assign bus.RAMOE_b   = oe_b_q;
  assign bus.RAMWE_b   = we_b_q;
  assign bus.ADR       = adr_q;
  assign bus.dat_out   = dout_q;
  assign bus.dat_oe    = dat_oe_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
